// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer: owns the PC, runs imem req/ack reads and hands words to decode
// over valid/ready. Every output is driven straight from a register.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] ADDR_MASK = 32'h0000_FFFF,
  parameter int unsigned MAX_WAIT  = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  output logic        halted,
  output logic        fault
);

  localparam int CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);

  // state | meaning
  // IDLE  | out of reset, waiting for start
  // FETCH | imem_req held until ack or timeout
  // ISSUE | inst_valid held until decode consumes it
  // HALT  | stopped; only rst leaves
  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, HALT} state_t;

  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] wait_q, wait_d;
  logic          halt_pend_q, halt_pend_d;
  logic          req_q, req_d;
  logic          valid_q, valid_d;
  logic [31:0]   inst_q, inst_d;
  logic [31:0]   inst_pc_q, inst_pc_d;
  logic          halted_q, halted_d;
  logic          fault_q, fault_d;
  logic [31:0]   pc_seq;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      wait_q      <= '0;
      halt_pend_q <= 1'b0;
      req_q       <= 1'b0;
      valid_q     <= 1'b0;
      inst_q      <= '0;
      inst_pc_q   <= '0;
      halted_q    <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      wait_q      <= wait_d;
      halt_pend_q <= halt_pend_d;
      req_q       <= req_d;
      valid_q     <= valid_d;
      inst_q      <= inst_d;
      inst_pc_q   <= inst_pc_d;
      halted_q    <= halted_d;
      fault_q     <= fault_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    wait_d      = wait_q;
    halt_pend_d = halt_pend_q;
    req_d       = req_q;
    valid_d     = valid_q;
    inst_d      = inst_q;
    inst_pc_d   = inst_pc_q;
    halted_d    = halted_q;
    fault_d     = fault_q;
    // carry out of bit 31 is dropped before masking
    pc_seq      = (pc_q + 32'd4) & ADDR_MASK;

    case (state_q)
      IDLE: begin
        if (halt_req) begin
          state_d  = HALT;
          halted_d = 1'b1;
        end else if (start) begin
          state_d     = FETCH;
          req_d       = 1'b1;
          wait_d      = '0;
          halt_pend_d = 1'b0;
        end
      end
      FETCH: begin
        if (halt_req) halt_pend_d = 1'b1;
        if (imem_ack) begin
          req_d = 1'b0;
          if (halt_pend_q) begin
            state_d  = HALT;
            halted_d = 1'b1;
          end else begin
            inst_d    = imem_rdata;
            inst_pc_d = pc_q;
            valid_d   = 1'b1;
            state_d   = ISSUE;
          end
        end else if (wait_q == WAIT_LAST) begin
          fault_d  = 1'b1;
          req_d    = 1'b0;
          state_d  = HALT;
          halted_d = 1'b1;
        end else begin
          wait_d = wait_q + CW'(1);
        end
      end
      ISSUE: begin
        if (halt_req) begin
          valid_d  = 1'b0;
          state_d  = HALT;
          halted_d = 1'b1;
        end else if (inst_ready) begin
          valid_d = 1'b0;
          if (redirect_valid && redirect_pc[1:0] != 2'b00) begin
            fault_d  = 1'b1;
            state_d  = HALT;
            halted_d = 1'b1;
          end else begin
            pc_d        = redirect_valid ? (redirect_pc & ADDR_MASK) : pc_seq;
            state_d     = FETCH;
            req_d       = 1'b1;
            wait_d      = '0;
            halt_pend_d = 1'b0;
          end
        end
      end
      HALT: begin
        req_d    = 1'b0;
        valid_d  = 1'b0;
        halted_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign imem_req   = req_q;
  assign imem_addr  = pc_q;
  assign inst_valid = valid_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign halted     = halted_q;
  assign fault      = fault_q;

endmodule
